uart_tx_fifo: RTL and testbench

//  Synthesizable 8N1 UART transmitter with a small byte FIFO, driving the serial TX pin toward the host.
//  It is the device-side counterpart of the UART receive path in the simulation UART model.

---
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO over a valid/ready handshake.
// Frames are sent LSB-first and run back-to-back whenever the FIFO holds another byte.
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   fifo_count_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               tx_q, busy_q;
  logic               push, pop, bit_end, not_empty;

  assign not_empty  = (count_q != '0);
  assign bit_end    = (cnt_q == CNT_LAST);
  assign tx_ready_o = (count_q != FULL);
  assign push       = tx_valid_i & tx_ready_o;
  // Pop only when the serializer is free to load: from IDLE, or at the end of a stop bit.
  assign pop        = not_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + (FIFO_AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: accepted bytes go to a scoreboard queue and a
// serial receive model on TX pops and compares them; TX timing is checked per cycle.
module tb_uart_tx_fifo;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_line, busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int rx_good = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_AW(2)) dut (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .tx_o(tx_line), .busy_o(busy), .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected TX level at cycle offset k (0..99) of a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < CPB) return 1'b0;
    if (k < 9 * CPB) return b[(k - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] b, input int budget);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < budget) begin
      tick();
      n++;
    end
    chk("push_timeout", (n < budget), 1);
    if (tx_ready) exp_q.push_back(b);
    tick();
    last_acc = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || fifo_count != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n < budget), 1);
  endtask

  // Serial receive model: samples mid-bit, drops any frame that overlaps a reset.
  initial begin : uart_model
    logic [7:0] b;
    logic       ab, stop_bit;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && tx_line === 1'b0) begin
        ab = 1'b0;
        for (int c = 0; c < CPB / 2; c++) begin @(posedge clk); #2; ab |= rst; end
        for (int i = 0; i < 8; i++) begin
          for (int c = 0; c < CPB; c++) begin @(posedge clk); #2; ab |= rst; end
          b[i] = tx_line;
        end
        for (int c = 0; c < CPB; c++) begin @(posedge clk); #2; ab |= rst; end
        stop_bit = tx_line;
        if (!ab) begin
          chk("rx_stop", stop_bit, 1);
          if (exp_q.size() == 0) begin
            chk("rx_unexpected", b, 8'hxx);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", b, e);
          end
          rx_good++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a, bb, c, d, n, bad;

    // 1. reset
    repeat (3) tick();
    chk("rst_tx", tx_line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    repeat (2) tick();

    // 2. single byte 0x55, per-cycle TX
    push_byte(8'h55, 10);
    chk("t2_count", fifo_count, 1);
    chk("t2_tx_pre", tx_line, 1);
    tick();
    chk("t2_busy", busy, 1);
    for (int j = 0; j < 10 * CPB; j++) begin
      chk("t2_tx", tx_line, exp_tx(8'h55, j));
      tick();
    end
    chk("t2_busy_end", busy, 0);
    chk("t2_tx_end", tx_line, 1);

    // 3. backpressure 0x41..0x46
    push_byte(8'h41, 10);
    a = last_acc;
    for (int k = 1; k < 5; k++) push_byte(8'h41 + 8'(k), 10);
    chk("t3_last5", last_acc, a + 4);
    chk("t3_count_full", fifo_count, 4);
    chk("t3_ready_full", tx_ready, 0);
    push_byte(8'h46, 300);
    // Ready is registered, so the slot freed by the first stop-end pop is usable one edge later.
    chk("t3_acc6", last_acc, a + 1 + 10 * CPB + 1);
    n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    chk("t3_busy_end", cyc, a + 1 + 60 * CPB);

    // 4. simultaneous push/pop at final stop edge
    tick();
    push_byte(8'h5A, 10);
    bb = last_acc;
    push_byte(8'hC3, 10);
    while (cyc < bb + 10 * CPB) tick();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    chk("t4_ready", tx_ready, 1);
    exp_q.push_back(8'h3C);
    tick();
    tx_valid = 1'b0;
    chk("t4_count", fifo_count, 1);
    chk("t4_start", tx_line, 0);
    wait_idle(500);

    // 5. reset during bit 3 of 0xA5 with two bytes queued
    tick();
    push_byte(8'hA5, 10);
    c = last_acc;
    push_byte(8'h11, 10);
    push_byte(8'h22, 10);
    chk("t5_queued", fifo_count, 2);
    while (cyc < c + 1 + 4 * CPB + 3) tick();
    rst = 1'b1;
    tick();
    chk("t5_tx", tx_line, 1);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      tick();
      if (tx_line !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t5_quiet", bad, 0);

    // 6. data extremes 0x00 then 0xFF
    push_byte(8'h00, 10);
    d = last_acc;
    push_byte(8'hFF, 10);
    chk("t6_cyc", cyc, d + 1);
    for (int j = 0; j < 20 * CPB; j++) begin
      chk("t6_tx", tx_line, exp_tx((j < 10 * CPB) ? 8'h00 : 8'hFF, j % (10 * CPB)));
      tick();
    end
    chk("t6_busy_end", busy, 0);

    repeat (20) tick();
    chk("rx_total", rx_good, 12);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
